// File: rtl/mux16_bus_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 datapath mux into one registered
// output stage; grants last one burst, capped at MAX_BURST beats.
module mux16_bus_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             select,
    output logic [1:0]       grant
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t           state;
    logic             prio;
    logic [CNT_W-1:0] beat_cnt;

    logic             out_free;
    logic             accept;
    logic             accept_last;
    logic [WIDTH-1:0] mux_data;

    // The output register can take a beat when empty or being drained this cycle.
    assign out_free    = !out_valid || out_ready;
    assign a_ready     = (state == GNT_A) && out_free;
    assign b_ready     = (state == GNT_B) && out_free;
    assign mux_data    = select ? b_data : a_data;
    assign accept      = (a_valid && a_ready) || (b_valid && b_ready);
    assign accept_last = (select ? b_last : a_last) ||
                         (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            select    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            prio      <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_last  <= accept_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // prio == 0 favours A on a tie, prio == 1 favours B.
                    if (a_valid && (!b_valid || !prio)) begin
                        state  <= GNT_A;
                        select <= 1'b0;
                        grant  <= 2'b01;
                    end else if (b_valid) begin
                        state  <= GNT_B;
                        select <= 1'b1;
                        grant  <= 2'b10;
                    end
                end
                GNT_A, GNT_B: begin
                    if (accept) begin
                        if (accept_last) begin
                            state    <= IDLE;
                            grant    <= 2'b00;
                            prio     <= (state == GNT_A);
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
